// File: rtl/timer_pkg.sv
// Shared definitions for the pinmux timer engine: tick-base encodings and
// the bit layout of the per-channel configuration word.
package timer_pkg;

  typedef enum logic [1:0] {
    TICK_1US  = 2'b00,
    TICK_1MS  = 2'b01,
    TICK_1S   = 2'b10,
    TICK_NONE = 2'b11
  } tick_sel_e;

  localparam int unsigned RELOAD_MSB = 15;
  localparam int unsigned EN_BIT     = 16;
  localparam int unsigned SEL_LSB    = 17;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CFG_W      = SEL_LSB + SEL_W;
  localparam int unsigned CNT_W      = RELOAD_MSB + 1;

  // Reserved select value yields no tick, so the channel simply holds.
  function automatic logic tick_pick(input tick_sel_e sel, input logic p_us,
                                     input logic p_ms, input logic p_s);
    case (sel)
      TICK_1US: return p_us;
      TICK_1MS: return p_ms;
      TICK_1S:  return p_s;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One periodic down-counter channel with auto-reload and a one-cycle
// expiry pulse; the load strobe takes priority over everything else.
module timer_chan
  import timer_pkg::*;
(
  input  logic             mclk,
  input  logic             h_reset_n,
  input  logic             update,
  input  logic [CFG_W-1:0] cfg,
  input  logic             pulse_1us,
  input  logic             pulse_1ms,
  input  logic             pulse_1s,
  output logic [CNT_W-1:0] timer_cnt,
  output logic             timer_intr
);

  logic [CNT_W-1:0] reload;
  logic             enable;
  tick_sel_e        sel;
  logic             tick;

  always_comb begin
    reload = cfg[RELOAD_MSB:0];
    enable = cfg[EN_BIT];
    sel    = tick_sel_e'(cfg[SEL_LSB +: SEL_W]);
    tick   = tick_pick(sel, pulse_1us, pulse_1ms, pulse_1s);
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      timer_cnt  <= '0;
      timer_intr <= 1'b0;
    end else if (update) begin
      timer_cnt  <= reload;
      timer_intr <= 1'b0;
    end else if (enable && tick) begin
      if (timer_cnt == '0) begin
        timer_cnt  <= reload;
        timer_intr <= 1'b1;
      end else begin
        timer_cnt  <= timer_cnt - CNT_W'(1);
        timer_intr <= 1'b0;
      end
    end else begin
      timer_intr <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer engine: 1 us / 1 ms / 1 s timebase prescaler chain feeding three
// independent periodic down-counter channels.
module timer_ctrl #(
  parameter int unsigned MS_DIV = 1000,
  parameter int unsigned S_DIV  = 1000
) (
  input  logic        mclk,
  input  logic        h_reset_n,
  input  logic [9:0]  cfg_pulse_1us,
  input  logic [2:0]  cfg_timer_update,
  input  logic [18:0] cfg_timer0,
  input  logic [18:0] cfg_timer1,
  input  logic [18:0] cfg_timer2,
  output logic        pulse_1us,
  output logic        pulse_1ms,
  output logic        pulse_1s,
  output logic [15:0] timer_cnt0,
  output logic [15:0] timer_cnt1,
  output logic [15:0] timer_cnt2,
  output logic [2:0]  timer_intr
);
  import timer_pkg::*;

  localparam int unsigned MS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned S_W  = (S_DIV > 1) ? $clog2(S_DIV) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);
  localparam logic [S_W-1:0]  S_LAST  = S_W'(S_DIV - 1);

  logic [9:0]      us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic [S_W-1:0]  s_cnt;

  // >= rather than == so lowering the config mid-count cannot overrun.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      us_cnt    <= '0;
      pulse_1us <= 1'b0;
    end else if (us_cnt >= cfg_pulse_1us) begin
      us_cnt    <= '0;
      pulse_1us <= 1'b1;
    end else begin
      us_cnt    <= us_cnt + 10'd1;
      pulse_1us <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      ms_cnt    <= '0;
      pulse_1ms <= 1'b0;
    end else begin
      pulse_1ms <= 1'b0;
      if (pulse_1us) begin
        if (ms_cnt == MS_LAST) begin
          ms_cnt    <= '0;
          pulse_1ms <= 1'b1;
        end else begin
          ms_cnt <= ms_cnt + MS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      s_cnt    <= '0;
      pulse_1s <= 1'b0;
    end else begin
      pulse_1s <= 1'b0;
      if (pulse_1ms) begin
        if (s_cnt == S_LAST) begin
          s_cnt    <= '0;
          pulse_1s <= 1'b1;
        end else begin
          s_cnt <= s_cnt + S_W'(1);
        end
      end
    end
  end

  timer_chan u_chan0 (
    .mclk       (mclk),
    .h_reset_n  (h_reset_n),
    .update     (cfg_timer_update[0]),
    .cfg        (cfg_timer0),
    .pulse_1us  (pulse_1us),
    .pulse_1ms  (pulse_1ms),
    .pulse_1s   (pulse_1s),
    .timer_cnt  (timer_cnt0),
    .timer_intr (timer_intr[0])
  );

  timer_chan u_chan1 (
    .mclk       (mclk),
    .h_reset_n  (h_reset_n),
    .update     (cfg_timer_update[1]),
    .cfg        (cfg_timer1),
    .pulse_1us  (pulse_1us),
    .pulse_1ms  (pulse_1ms),
    .pulse_1s   (pulse_1s),
    .timer_cnt  (timer_cnt1),
    .timer_intr (timer_intr[1])
  );

  timer_chan u_chan2 (
    .mclk       (mclk),
    .h_reset_n  (h_reset_n),
    .update     (cfg_timer_update[2]),
    .cfg        (cfg_timer2),
    .pulse_1us  (pulse_1us),
    .pulse_1ms  (pulse_1ms),
    .pulse_1s   (pulse_1s),
    .timer_cnt  (timer_cnt2),
    .timer_intr (timer_intr[2])
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed timebase/channel scenarios,
// a table of channel vectors, and a randomized run against a tick-level model.
module tb_timer_ctrl;

  localparam int MS_DIV = 1000;
  localparam int S_DIV  = 3;

  logic        mclk = 1'b0;
  logic        h_reset_n = 1'b0;
  logic [9:0]  cfg_pulse_1us = '0;
  logic [2:0]  cfg_timer_update = '0;
  logic [18:0] cfg_tm [3];
  logic        pulse_1us, pulse_1ms, pulse_1s;
  logic [15:0] timer_cnt0, timer_cnt1, timer_cnt2;
  logic [2:0]  timer_intr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  timer_ctrl #(.MS_DIV(MS_DIV), .S_DIV(S_DIV)) dut (
    .mclk             (mclk),
    .h_reset_n        (h_reset_n),
    .cfg_pulse_1us    (cfg_pulse_1us),
    .cfg_timer_update (cfg_timer_update),
    .cfg_timer0       (cfg_tm[0]),
    .cfg_timer1       (cfg_tm[1]),
    .cfg_timer2       (cfg_tm[2]),
    .pulse_1us        (pulse_1us),
    .pulse_1ms        (pulse_1ms),
    .pulse_1s         (pulse_1s),
    .timer_cnt0       (timer_cnt0),
    .timer_cnt1       (timer_cnt1),
    .timer_cnt2       (timer_cnt2),
    .timer_intr       (timer_intr)
  );

  always #5 mclk = ~mclk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [18:0] mk_cfg(input int reload, input bit en, input int sel);
    logic [1:0] s;
    s = 2'(sel);
    return {s, en, 16'(reload)};
  endfunction

  // Reference model: ticks counted as event totals, channels by the rule list.
  int m_us_phase, m_us_total, m_ms_total;
  bit m_pus, m_pms, m_ps;
  int m_cnt [3];
  bit m_intr [3];

  task automatic model_reset();
    m_us_phase = 0; m_us_total = 0; m_ms_total = 0;
    m_pus = 0; m_pms = 0; m_ps = 0;
    for (int c = 0; c < 3; c++) begin m_cnt[c] = 0; m_intr[c] = 0; end
  endtask

  task automatic model_step();
    bit nu, nm, ns, tk;
    int reload, sel;
    bit en;
    nu = (m_us_phase >= int'(cfg_pulse_1us));
    m_us_phase = nu ? 0 : m_us_phase + 1;
    nm = 0;
    if (m_pus) begin m_us_total++; nm = ((m_us_total % MS_DIV) == 0); end
    ns = 0;
    if (m_pms) begin m_ms_total++; ns = ((m_ms_total % S_DIV) == 0); end
    for (int c = 0; c < 3; c++) begin
      reload = int'(cfg_tm[c][15:0]);
      en     = cfg_tm[c][16];
      sel    = int'(cfg_tm[c][18:17]);
      tk     = (sel == 0) ? m_pus : (sel == 1) ? m_pms : (sel == 2) ? m_ps : 1'b0;
      m_intr[c] = 0;
      if (cfg_timer_update[c]) m_cnt[c] = reload;
      else if (en && tk) begin
        if (m_cnt[c] == 0) begin m_intr[c] = 1; m_cnt[c] = reload; end
        else m_cnt[c] = m_cnt[c] - 1;
      end
    end
    m_pus = nu; m_pms = nm; m_ps = ns;
  endtask

  always @(posedge mclk) begin
    if (!h_reset_n) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      check("rnd_pulses", int'({pulse_1us, pulse_1ms, pulse_1s}), int'({m_pus, m_pms, m_ps}));
      check("rnd_cnt0", int'(timer_cnt0), m_cnt[0]);
      check("rnd_cnt1", int'(timer_cnt1), m_cnt[1]);
      check("rnd_cnt2", int'(timer_cnt2), m_cnt[2]);
      check("rnd_intr", int'(timer_intr), int'({m_intr[2], m_intr[1], m_intr[0]}));
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic bit evt(input int which);
    case (which)
      0: return pulse_1us;
      1: return pulse_1ms;
      2: return pulse_1s;
      3: return timer_intr[1];
      default: return timer_intr != 3'b000;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (!evt(which) && n < bound);
  endtask

  task automatic do_reset();
    h_reset_n = 1'b0;
    cfg_timer_update = '0;
    for (int c = 0; c < 3; c++) cfg_tm[c] = '0;
    tick(); tick();
    h_reset_n = 1'b1;
  endtask

  task automatic load(input int c, input int reload, input bit en, input int sel);
    cfg_tm[c] = mk_cfg(reload, en, sel);
    cfg_timer_update = 3'(1 << c);
    tick();
    cfg_timer_update = '0;
  endtask

  typedef struct {
    int reload;
    int ticks;
    int exp_intr;
    int exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, icnt, got, guard;
    for (int c = 0; c < 3; c++) cfg_tm[c] = '0;

    // Reset state
    #12;
    check("reset_outs", int'({pulse_1us, pulse_1ms, pulse_1s, timer_intr}), 0);
    check("reset_cnts", int'(timer_cnt0 | timer_cnt1 | timer_cnt2), 0);

    // 1 us / 1 ms timebase with cfg=9, then lower to 4 mid-count
    do_reset();
    cfg_pulse_1us = 10'd9;
    wait_evt(0, 30, n);
    wait_evt(0, 30, n);
    check("us_period_10", n, 10);
    tick();
    check("us_width", int'(pulse_1us), 0);
    wait_evt(1, 12000, n);
    wait_evt(1, 12000, n);
    check("ms_period_10000", n, 10000);
    wait_evt(0, 30, n);
    repeat (6) tick();
    cfg_pulse_1us = 10'd4;
    wait_evt(0, 30, n);
    check("us_lowered_le5", int'(n <= 5), 1);
    wait_evt(0, 30, n);
    check("us_period_5", n, 5);

    // 1 s timebase (S_DIV=3 ms) with cfg=0
    do_reset();
    cfg_pulse_1us = 10'd0;
    wait_evt(2, 4000, n);
    wait_evt(2, 4000, n);
    check("s_period_3000", n, 3000);
    tick();
    check("s_width", int'(pulse_1s), 0);

    // Table-driven ch0 vectors, 1 us base at cfg=3
    vecs[0] = '{reload: 3, ticks: 8, exp_intr: 2, exp_cnt: 3};
    vecs[1] = '{reload: 0, ticks: 5, exp_intr: 5, exp_cnt: 0};
    vecs[2] = '{reload: 5, ticks: 3, exp_intr: 0, exp_cnt: 2};
    vecs[3] = '{reload: 2, ticks: 7, exp_intr: 2, exp_cnt: 1};
    vecs[4] = '{reload: 1, ticks: 6, exp_intr: 3, exp_cnt: 1};
    do_reset();
    cfg_pulse_1us = 10'd3;
    for (int v = 0; v < 5; v++) begin
      wait_evt(0, 20, n);
      tick();
      load(0, vecs[v].reload, 1'b1, 0);
      icnt = 0; got = 0; guard = 0;
      while (got < vecs[v].ticks && guard < 200) begin
        tick(); guard++;
        if (pulse_1us) got++;
        if (timer_intr[0]) icnt++;
      end
      tick();
      if (timer_intr[0]) icnt++;
      check($sformatf("vec%0d_intr", v), icnt, vecs[v].exp_intr);
      check($sformatf("vec%0d_cnt", v), int'(timer_cnt0), vecs[v].exp_cnt);
    end

    // ch1 reload=0 on 1 ms base, then reserved select holds
    do_reset();
    cfg_pulse_1us = 10'd0;
    load(1, 0, 1'b1, 1);
    wait_evt(3, 1200, n);
    wait_evt(3, 1200, n);
    check("ch1_ms_period", n, 1000);
    cfg_tm[1] = mk_cfg(4, 1'b1, 1);
    wait_evt(3, 1200, n);
    wait_evt(3, 6000, n);
    check("ch1_ms_reload4", n, 5000);
    wait_evt(1, 1200, n);
    tick();
    cfg_tm[1] = mk_cfg(4, 1'b1, 3);
    got = int'(timer_cnt1);
    icnt = 0;
    repeat (2500) begin tick(); if (timer_intr[1]) icnt++; end
    check("ch1_none_intr", icnt, 0);
    check("ch1_none_hold", int'(timer_cnt1), got);
    check("ch1_none_cnt", got, 3);

    // ch2 freeze and resume
    cfg_pulse_1us = 10'd3;
    load(2, 9, 1'b1, 0);
    guard = 0;
    while (timer_cnt2 != 16'd5 && guard < 100) begin tick(); guard++; end
    check("ch2_reach5", int'(timer_cnt2), 5);
    cfg_tm[2] = mk_cfg(9, 1'b0, 0);
    icnt = 0;
    repeat (80) begin tick(); if (timer_intr[2]) icnt++; end
    check("ch2_frozen", int'(timer_cnt2), 5);
    check("ch2_frozen_intr", icnt, 0);
    cfg_tm[2] = mk_cfg(9, 1'b1, 0);
    guard = 0;
    while (timer_cnt2 == 16'd5 && guard < 10) begin tick(); guard++; end
    check("ch2_resume", int'(timer_cnt2), 4);

    // Update strobe coinciding with an expiring tick
    load(0, 2, 1'b1, 0);
    guard = 0;
    while (!(timer_cnt0 == 16'd0 && pulse_1us) && guard < 100) begin tick(); guard++; end
    check("coll_setup", int'({timer_cnt0 == 16'd0, pulse_1us}), 3);
    load(0, 6, 1'b1, 0);
    check("coll_cnt", int'(timer_cnt0), 6);
    check("coll_intr", int'(timer_intr[0]), 0);

    // All channels together, then asynchronous reset mid-count
    do_reset();
    cfg_pulse_1us = 10'd3;
    for (int c = 0; c < 3; c++) cfg_tm[c] = mk_cfg(1, 1'b1, 0);
    cfg_timer_update = 3'b111;
    tick();
    cfg_timer_update = '0;
    wait_evt(4, 20, n);
    check("all_intr", int'(timer_intr), 7);
    repeat (2) tick();
    #2 h_reset_n = 1'b0;
    #1;
    check("areset_outs", int'({pulse_1us, pulse_1ms, pulse_1s, timer_intr}), 0);
    check("areset_cnts", int'(timer_cnt0 | timer_cnt1 | timer_cnt2), 0);
    tick();

    // Randomized run against the model
    do_reset();
    cfg_pulse_1us = 10'(1);
    chk_en = 1'b1;
    repeat (20000) begin
      cfg_timer_update = '0;
      if ($urandom_range(0, 199) == 0) cfg_pulse_1us = 10'($urandom_range(0, 3));
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 15) == 0) cfg_timer_update[c] = 1'b1;
        if ($urandom_range(0, 63) == 0)
          cfg_tm[c] = mk_cfg($urandom_range(0, 5), $urandom_range(0, 3) != 0,
                             ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 3));
      end
      tick();
    end
    chk_en = 1'b0;
    cfg_timer_update = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
